// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encoding, driver FSM states, opcode legality helper.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drv_state_t;

  // 101 and 110 have no ALU meaning; they are answered locally with an error.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  // Ops that only pulse start for one cycle and never wait for done.
  function automatic logic op_no_done(input logic [2:0] op);
    return (op == NO_OP) || (op == RST_OP);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_driver_if.sv
// Command and response streams between a command source and the TinyALU driver.
interface tinyalu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;

  // Command source / response consumer side.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_err, rsp_timeout
  );

  // Driver side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/tinyalu_drv_timer.sv
// Start-high cycle counter: cleared while idle, counts enabled cycles,
// flags the LIMIT-th enabled cycle so the FSM can abort on that edge.
module tinyalu_drv_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
  localparam logic [W-1:0] LAST_W  = W'(LIMIT - 1);

  logic [W-1:0] count_reg;

  // Count enabled cycles, saturating at LIMIT so the value never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT_W)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expire = enable && (count_reg == LAST_W);
endmodule

// File: rtl/tinyalu_cmd_driver.sv
// TinyALU initiator: accepts one command at a time, runs the start/done
// handshake with timeout, and returns the result on the response stream.
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tinyalu_cmd_driver_if.slave  bus,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result,
  output logic [CNT_W-1:0]     rsp_count,
  output logic                 spurious_done
);

  drv_state_t       state_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic             rsp_timeout_reg;
  logic [15:0]      rsp_result_reg;
  logic [7:0]       alu_a_reg;
  logic [7:0]       alu_b_reg;
  logic [2:0]       alu_op_reg;
  logic             alu_start_reg;
  logic [CNT_W-1:0] rsp_count_reg;
  logic             spurious_reg;
  logic             timer_expire;

  // The timer spans every start-high cycle (START plus WAIT) of one operation.
  tinyalu_drv_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == ST_IDLE),
    .enable ((state_reg == ST_START) || (state_reg == ST_WAIT)),
    .expire (timer_expire)
  );

  // Driver FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cmd_ready_reg   <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_result_reg  <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      alu_start_reg   <= 1'b0;
      rsp_count_reg   <= '0;
      spurious_reg    <= 1'b0;
    end else begin
      if (alu_done && (state_reg != ST_WAIT)) begin
        spurious_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            if (op_illegal(bus.cmd_op)) begin
              // Answered locally; ALU pins keep their previous values.
              rsp_valid_reg  <= 1'b1;
              rsp_err_reg    <= 1'b1;
              rsp_result_reg <= '0;
              state_reg      <= ST_RESP;
            end else begin
              alu_a_reg     <= bus.cmd_a;
              alu_b_reg     <= bus.cmd_b;
              alu_op_reg    <= bus.cmd_op;
              alu_start_reg <= 1'b1;
              state_reg     <= ST_START;
            end
          end
        end
        ST_START: begin
          if (op_no_done(alu_op_reg)) begin
            alu_start_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= '0;
            state_reg      <= ST_RESP;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // done is checked first so it wins over a same-cycle timeout.
          if (alu_done) begin
            alu_start_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= alu_result;
            state_reg      <= ST_RESP;
          end else if (timer_expire) begin
            alu_start_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_result_reg  <= '0;
            state_reg       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_count_reg   <= rsp_count_reg + CNT_W'(1);
            cmd_ready_reg   <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_result  = rsp_result_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign alu_A           = alu_a_reg;
  assign alu_B           = alu_b_reg;
  assign alu_op          = alu_op_reg;
  assign alu_start       = alu_start_reg;
  assign rsp_count       = rsp_count_reg;
  assign spurious_done   = spurious_reg;

endmodule
